alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage datapath slice of the single-cycle LEGv8 CPU.
- Decodes ALUOp1/ALUOp0 plus instruction[31:21] into a 4-bit ALU operation.
- Performs the 64-bit ALU operation and zero detection.
- Computes PC+4, the branch target PC+(imm<<2), and next PC. Every output is registered once before use.

Parameters:
- WIDTH, 64, datapath width for operands, PC and results.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- alu_op1  in  1  ALUOp1 from Control.
- alu_op0  in  1  ALUOp0 from Control.
- opcode  in  11  instruction[31:21].
- alu_src  in  1  0 selects reg_b, 1 selects imm as ALU operand B.
- branch  in  1  Branch control bit.
- operand_a  in  WIDTH  register read data 1.
- reg_b  in  WIDTH  register read data 2.
- imm  in  WIDTH  sign-extended immediate.
- pc  in  WIDTH  current PC.
- alu_opcode  out  4  registered decoded operation.
- result  out  WIDTH  registered ALU result.
- zero  out  1  registered flag, 1 when the ALU result is all zeros.
- pc_plus4  out  WIDTH  registered pc+PC_STEP.
- branch_target  out  WIDTH  registered pc+(imm<<2).
- take_branch  out  1  registered branch & zero.
- next_pc  out  WIDTH  registered: branch_target if take_branch, else pc_plus4.
- illegal_op  out  1  registered flag, 1 when an R-type opcode is not decoded.

Behaviour:
- ALU control decode is combinational, with priority in this order:
  - alu_op1=0, alu_op0=0: 0010 (add; LDUR/STUR).
  - alu_op0=1 (either alu_op1 value): 0111 (pass B; CBZ).
  - alu_op1=1, alu_op0=0: decode opcode.
    - 10001011000 (ADD) -> 0010.
    - 11001011000 (SUB) -> 0110.
    - 10001010000 (AND) -> 0000.
    - 10101010000 (ORR) -> 0001.
    - Any other opcode -> 0010 with illegal_op=1.
  - illegal_op is 0 for all other cases.
- ALU operand B = alu_src ? imm : reg_b.
- ALU operations:
  - 0000: A&B.
  - 0001: A|B.
  - 0010: A+B.
  - 0110: A-B.
  - 0111: B.
  - 1100: ~(A|B).
  - Any other code: result 0.
- All arithmetic is modulo 2^WIDTH. Carry and borrow are discarded; no overflow flag.
- zero = (ALU result == 0), computed on the same result.
- Adders are plain WIDTH-bit unsigned modular adds.
  - pc_plus4 wraps, e.g. all-ones+4 = 3.
  - imm<<2 drops the top two bits.
- take_branch = branch & zero.
- next_pc selection uses the same-cycle combinational values.
- Latency: inputs sampled at rising edge N appear on all outputs after edge N. Exactly 1 cycle, no handshake; a new operation is accepted every cycle.
- Reset: when reset=0 at a rising edge, every output goes to 0, including alu_opcode=0000, zero=0, take_branch=0 and next_pc=0. Inputs during reset are ignored. The first valid outputs appear one edge after reset returns to 1. Reset asserted mid-stream discards the in-flight result.

Decomposition:
- Shared package (legv8_pkg):
  - ALU op constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR.
  - R-type opcode constants: OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR.
  - WIDTH default.
- One natural sub-module: alu_ctrl_decode, the combinational ALUOp/opcode decoder.
- The ALU core and the adders stay inline.

Test Plan:
- Reset: hold reset=0 for 2 edges with random inputs -> all outputs 0. Release reset -> first outputs appear after the next edge.
- ADD R-type: op1=1, op0=0, opcode=10001011000, alu_src=0, A=5, reg_b=7 -> alu_opcode=0010, result=12, zero=0, illegal_op=0.
- SUB to zero, then ORR: with branch=1, pc=0x100, imm=3:
  - SUB, A=B=0x1234 -> result=0, zero=1, take_branch=1, branch_target=0x10C, next_pc=0x10C.
  - Next cycle ORR, 0xF0|0x0F -> result=0xFF, zero=0, next_pc=0x104.
- CBZ: op0=1, reg_b=0, branch=1 -> alu_opcode=0111, zero=1, take_branch=1.
  - Repeat with reg_b=9 -> take_branch=0, next_pc=pc+4.
- Wrap: LDUR path (op1=op0=0), alu_src=1, A=0xFFFF_FFFF_FFFF_FFFF, imm=1 -> result=0, zero=1.
  - pc=0xFFFF_FFFF_FFFF_FFFC -> pc_plus4=0.
  - imm=-1 (all ones) -> branch_target=pc-4.
- Illegal opcode: op1=1, op0=0, opcode=11111111111, A=2, B=3 -> illegal_op=1, alu_opcode=0010, result=5. Next cycle with a legal opcode -> illegal_op=0.

Source files
------------

// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : legv8_pkg
//  Description : Shared constants for the LEGv8 execute stage: ALU operation
//                codes, R-type opcode patterns and the default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package legv8_pkg;

    // Default datapath width for operands, PC and results
    localparam int DATA_WIDTH = 64;

    // 4-bit ALU operation codes
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    // R-type opcode patterns, instruction[31:21]
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

endpackage : legv8_pkg
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_decode
//  Description : Combinational ALU control. Maps ALUOp1/ALUOp0 and the R-type
//                opcode field to a 4-bit ALU operation and flags R-type
//                opcodes that are not recognised.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import legv8_pkg::*;
(
    input  logic        alu_op1,
    input  logic        alu_op0,
    input  logic [10:0] opcode,
    output logic [3:0]  alu_opcode,
    output logic        illegal_op
);

    // Priority decode: memory add first, then CBZ pass-B, then R-type field
    always_comb begin
        alu_opcode = ALU_ADD;
        illegal_op = 1'b0;
        if (!alu_op1 && !alu_op0) begin
            alu_opcode = ALU_ADD;
        end else if (alu_op0) begin
            alu_opcode = ALU_PASSB;
        end else begin
            case (opcode)
                OPC_ADD: alu_opcode = ALU_ADD;
                OPC_SUB: alu_opcode = ALU_SUB;
                OPC_AND: alu_opcode = ALU_AND;
                OPC_ORR: alu_opcode = ALU_OR;
                default: begin
                    // Unknown R-type falls back to add so the datapath stays defined
                    alu_opcode = ALU_ADD;
                    illegal_op = 1'b1;
                end
            endcase
        end
    end

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : LEGv8 execute-stage slice. ALU control decode, 64-bit ALU
//                with zero detect, PC+4, branch target and next-PC select.
//                All outputs are registered with one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import legv8_pkg::*;
#(
    parameter int WIDTH   = DATA_WIDTH,
    parameter int PC_STEP = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alu_op1,
    input  logic             alu_op0,
    input  logic [10:0]      opcode,
    input  logic             alu_src,
    input  logic             branch,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic             take_branch,
    output logic [WIDTH-1:0] next_pc,
    output logic             illegal_op
);

    logic [3:0]       w_alu_opcode;
    logic             w_illegal;
    logic [WIDTH-1:0] w_operand_b;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_imm_shifted;
    logic [WIDTH-1:0] w_branch_target;
    logic             w_take_branch;
    logic [WIDTH-1:0] w_next_pc;

    logic [3:0]       r_alu_opcode;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_pc_plus4;
    logic [WIDTH-1:0] r_branch_target;
    logic             r_take_branch;
    logic [WIDTH-1:0] r_next_pc;
    logic             r_illegal;

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op1    (alu_op1),
        .alu_op0    (alu_op0),
        .opcode     (opcode),
        .alu_opcode (w_alu_opcode),
        .illegal_op (w_illegal)
    );

    assign w_operand_b = alu_src ? imm : reg_b;

    // ALU core; unassigned codes deliberately produce zero
    always_comb begin
        w_result = '0;
        case (w_alu_opcode)
            ALU_AND:   w_result = operand_a & w_operand_b;
            ALU_OR:    w_result = operand_a | w_operand_b;
            ALU_ADD:   w_result = operand_a + w_operand_b;
            ALU_SUB:   w_result = operand_a - w_operand_b;
            ALU_PASSB: w_result = w_operand_b;
            ALU_NOR:   w_result = ~(operand_a | w_operand_b);
            default:   w_result = '0;
        endcase
    end

    // Modular adders: carries out of the top bit are dropped
    assign w_zero          = (w_result == '0);
    assign w_pc_plus4      = pc + WIDTH'(PC_STEP);
    assign w_imm_shifted   = imm << 2;
    assign w_branch_target = pc + w_imm_shifted;
    assign w_take_branch   = branch & w_zero;
    assign w_next_pc       = w_take_branch ? w_branch_target : w_pc_plus4;

    // Output register stage; active-low reset clears everything
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_alu_opcode    <= '0;
            r_result        <= '0;
            r_zero          <= 1'b0;
            r_pc_plus4      <= '0;
            r_branch_target <= '0;
            r_take_branch   <= 1'b0;
            r_next_pc       <= '0;
            r_illegal       <= 1'b0;
        end else begin
            r_alu_opcode    <= w_alu_opcode;
            r_result        <= w_result;
            r_zero          <= w_zero;
            r_pc_plus4      <= w_pc_plus4;
            r_branch_target <= w_branch_target;
            r_take_branch   <= w_take_branch;
            r_next_pc       <= w_next_pc;
            r_illegal       <= w_illegal;
        end
    end

    assign alu_opcode    = r_alu_opcode;
    assign result        = r_result;
    assign zero          = r_zero;
    assign pc_plus4      = r_pc_plus4;
    assign branch_target = r_branch_target;
    assign take_branch   = r_take_branch;
    assign next_pc       = r_next_pc;
    assign illegal_op    = r_illegal;

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Directed self-checking bench for alu_exec_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clock;
    logic        reset;
    logic        alu_op1;
    logic        alu_op0;
    logic [10:0] opcode;
    logic        alu_src;
    logic        branch;
    logic [63:0] operand_a;
    logic [63:0] reg_b;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [3:0]  alu_opcode;
    logic [63:0] result;
    logic        zero;
    logic [63:0] pc_plus4;
    logic [63:0] branch_target;
    logic        take_branch;
    logic [63:0] next_pc;
    logic        illegal_op;

    int checks;
    int errors;

    alu_exec_unit #(
        .WIDTH   (64),
        .PC_STEP (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .alu_op1       (alu_op1),
        .alu_op0       (alu_op0),
        .opcode        (opcode),
        .alu_src       (alu_src),
        .branch        (branch),
        .operand_a     (operand_a),
        .reg_b         (reg_b),
        .imm           (imm),
        .pc            (pc),
        .alu_opcode    (alu_opcode),
        .result        (result),
        .zero          (zero),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .take_branch   (take_branch),
        .next_pc       (next_pc),
        .illegal_op    (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic o1, input logic o0, input logic [10:0] opc,
                          input logic src, input logic br, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] im, input logic [63:0] p);
        alu_op1 = o1; alu_op0 = o0; opcode = opc; alu_src = src; branch = br;
        operand_a = a; reg_b = b; imm = im; pc = p;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_opc"},  64'(alu_opcode), 64'd0);
        check({tag, "_res"},  result, 64'd0);
        check({tag, "_zero"}, 64'(zero), 64'd0);
        check({tag, "_pc4"},  pc_plus4, 64'd0);
        check({tag, "_bt"},   branch_target, 64'd0);
        check({tag, "_take"}, 64'(take_branch), 64'd0);
        check({tag, "_npc"},  next_pc, 64'd0);
        check({tag, "_ill"},  64'(illegal_op), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset held for two edges with random inputs
        reset = 1'b0;
        set_op(1'($urandom), 1'($urandom), 11'($urandom), 1'($urandom), 1'b1,
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom});
        tick();
        set_op(1'b1, 1'b0, 11'b10001011000, 1'b0, 1'b1, 64'd5, 64'd7, 64'd1, 64'h200);
        tick();
        check_all_zero("reset");

        // Release reset: outputs stay zero until the next edge
        reset = 1'b1;
        set_op(1'b1, 1'b0, 11'b10001011000, 1'b0, 1'b0, 64'd5, 64'd7, 64'd1, 64'h200);
        #2;
        check("release_before_edge", result, 64'd0);
        tick();
        check("add_opc",  64'(alu_opcode), 64'h2);
        check("add_res",  result, 64'd12);
        check("add_zero", 64'(zero), 64'd0);
        check("add_ill",  64'(illegal_op), 64'd0);
        check("add_pc4",  pc_plus4, 64'h204);
        check("add_npc",  next_pc, 64'h204);

        // SUB to zero with branch asserted
        set_op(1'b1, 1'b0, 11'b11001011000, 1'b0, 1'b1, 64'h1234, 64'h1234, 64'd3, 64'h100);
        tick();
        check("sub_opc",  64'(alu_opcode), 64'h6);
        check("sub_res",  result, 64'd0);
        check("sub_zero", 64'(zero), 64'd1);
        check("sub_take", 64'(take_branch), 64'd1);
        check("sub_bt",   branch_target, 64'h10C);
        check("sub_npc",  next_pc, 64'h10C);

        // ORR back-to-back
        set_op(1'b1, 1'b0, 11'b10101010000, 1'b0, 1'b1, 64'hF0, 64'h0F, 64'd3, 64'h100);
        tick();
        check("orr_opc",  64'(alu_opcode), 64'h1);
        check("orr_res",  result, 64'hFF);
        check("orr_zero", 64'(zero), 64'd0);
        check("orr_take", 64'(take_branch), 64'd0);
        check("orr_npc",  next_pc, 64'h104);

        // CBZ with zero register: branch taken
        set_op(1'b0, 1'b1, 11'b10001011000, 1'b0, 1'b1, 64'h55, 64'd0, 64'd3, 64'h100);
        tick();
        check("cbz0_opc",  64'(alu_opcode), 64'h7);
        check("cbz0_res",  result, 64'd0);
        check("cbz0_zero", 64'(zero), 64'd1);
        check("cbz0_take", 64'(take_branch), 64'd1);
        check("cbz0_npc",  next_pc, 64'h10C);

        // CBZ with nonzero register (op1=1 too, op0 still wins): not taken
        set_op(1'b1, 1'b1, 11'b11111111111, 1'b0, 1'b1, 64'h55, 64'd9, 64'd3, 64'h100);
        tick();
        check("cbz9_opc",  64'(alu_opcode), 64'h7);
        check("cbz9_res",  result, 64'd9);
        check("cbz9_take", 64'(take_branch), 64'd0);
        check("cbz9_npc",  next_pc, 64'h104);
        check("cbz9_ill",  64'(illegal_op), 64'd0);

        // LDUR path: wrap of the ALU add and of pc+4
        set_op(1'b0, 1'b0, 11'b00000000000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd77,
               64'd1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_opc",  64'(alu_opcode), 64'h2);
        check("wrap_res",  result, 64'd0);
        check("wrap_zero", 64'(zero), 64'd1);
        check("wrap_pc4",  pc_plus4, 64'd0);
        check("wrap_bt",   branch_target, 64'd0);
        check("wrap_take", 64'(take_branch), 64'd0);
        check("wrap_npc",  next_pc, 64'd0);

        // Negative immediate: branch target is pc-4
        imm = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check("neg_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("neg_bt",  branch_target, 64'hFFFF_FFFF_FFFF_FFF8);

        // imm<<2 drops the top bits
        set_op(1'b0, 1'b0, 11'b00000000000, 1'b0, 1'b0, 64'd1, 64'd2,
               64'h4000_0000_0000_0001, 64'd0);
        tick();
        check("shift_bt",  branch_target, 64'd4);
        check("shift_res", result, 64'd3);

        // Illegal R-type opcode
        set_op(1'b1, 1'b0, 11'b11111111111, 1'b0, 1'b0, 64'd2, 64'd3, 64'd0, 64'h40);
        tick();
        check("ill_flag", 64'(illegal_op), 64'd1);
        check("ill_opc",  64'(alu_opcode), 64'h2);
        check("ill_res",  result, 64'd5);

        // Legal AND right after clears the flag
        set_op(1'b1, 1'b0, 11'b10001010000, 1'b0, 1'b0, 64'hFF0, 64'h0FF, 64'd0, 64'h40);
        tick();
        check("and_ill", 64'(illegal_op), 64'd0);
        check("and_opc", 64'(alu_opcode), 64'h0);
        check("and_res", result, 64'h0F0);
        check("and_pc4", pc_plus4, 64'h44);

        // Mid-stream reset discards the in-flight operation
        reset = 1'b0;
        set_op(1'b1, 1'b0, 11'b10001011000, 1'b0, 1'b1, 64'd5, 64'd7, 64'd1, 64'h300);
        tick();
        check_all_zero("midreset");
        reset = 1'b1;
        tick();
        check("post_reset_res", result, 64'd12);
        check("post_reset_npc", next_pc, 64'h304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire
